// File: rtl/led_pkg.sv
// led_pkg: mode encoding, shift direction and PWM width shared by the LED pattern generator.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_COUNT   = 2'd0,
      MODE_ROTATE  = 2'd1,
      MODE_BOUNCE  = 2'd2,
      MODE_BREATHE = 2'd3
   } led_mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } led_dir_e;

   localparam int unsigned PWM_W = 8;

endpackage

// File: rtl/led_tick_div.sv
// led_tick_div: clock-enable prescaler, one-cycle oTICK every DIV enabled cycles; iCLR restarts the count.
module led_tick_div #(
   parameter int unsigned DIV = 12_500_000
) (
   input  logic iCLK,
   input  logic iRST_N,
   input  logic iEN,
   input  logic iCLR,
   output logic oTICK
);

   localparam int unsigned      CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      oTICK = iEN && !iCLR && (cnt_q == LAST);
      if (iCLR) begin
         cnt_d = '0;
      end else if (oTICK) begin
         cnt_d = '0;
      end else if (iEN) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: N-bit LED animator (count, rotate, bounce, breathe/blink) stepped by led_tick_div.
// Define LED_PWM_EN for PWM breathing in mode 3; otherwise mode 3 blinks all LEDs.
module led_pattern_gen #(
   parameter int unsigned N_LED = 8,
   parameter int unsigned DIV   = 12_500_000
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             iEN,
   input  logic [1:0]       iMODE,
   output logic [N_LED-1:0] oLED,
   output logic             oSTEP
);

   import led_pkg::*;

   localparam logic [N_LED-1:0] ONE = N_LED'(1);

   led_mode_e        mode_q, mode_d;
   led_dir_e         dir_q, dir_d;
   logic [N_LED-1:0] pat_q, pat_d;
   logic [N_LED-1:0] led_q, led_d;
   logic             step_q, step_d;
   logic             mode_chg;
   logic             tick;

`ifdef LED_PWM_EN
   logic [PWM_W-1:0] pwm_q, pwm_d;
   logic [PWM_W-1:0] duty_q, duty_d;
`endif

   assign mode_chg = (mode_q != led_mode_e'(iMODE));

   led_tick_div #(
      .DIV(DIV)
   ) u_tick_div (
      .iCLK  (iCLK),
      .iRST_N(iRST_N),
      .iEN   (iEN),
      .iCLR  (mode_chg),
      .oTICK (tick)
   );

   always_comb begin
      mode_d = mode_q;
      dir_d  = dir_q;
      pat_d  = pat_q;
      step_d = tick;
`ifdef LED_PWM_EN
      pwm_d  = pwm_q + PWM_W'(1);
      duty_d = duty_q;
`endif
      if (mode_chg) begin
         mode_d = led_mode_e'(iMODE);
         dir_d  = DIR_UP;
         pat_d  = '0;
         step_d = 1'b0;
`ifdef LED_PWM_EN
         duty_d = '0;
`endif
      end else if (tick) begin
         unique case (mode_q)
            MODE_COUNT: pat_d = pat_q + ONE;
            MODE_ROTATE: begin
               if ($onehot(pat_q)) begin
                  pat_d = (pat_q << 1) | (pat_q >> (N_LED - 1));
               end else begin
                  pat_d = ONE;
               end
            end
            MODE_BOUNCE: begin
               if (!$onehot(pat_q)) begin
                  pat_d = ONE;
                  dir_d = DIR_UP;
               end else if (N_LED > 1) begin
                  if (dir_q == DIR_UP) begin
                     if (pat_q[N_LED-1]) begin
                        dir_d = DIR_DOWN;
                        pat_d = pat_q >> 1;
                     end else begin
                        pat_d = pat_q << 1;
                     end
                  end else begin
                     if (pat_q[0]) begin
                        dir_d = DIR_UP;
                        pat_d = pat_q << 1;
                     end else begin
                        pat_d = pat_q >> 1;
                     end
                  end
               end
            end
            MODE_BREATHE: begin
`ifdef LED_PWM_EN
               // dir_q doubles as the duty ramp direction; only one user is active per mode
               if (dir_q == DIR_UP) begin
                  if (duty_q == '1) begin
                     dir_d  = DIR_DOWN;
                     duty_d = duty_q - PWM_W'(1);
                  end else begin
                     duty_d = duty_q + PWM_W'(1);
                  end
               end else begin
                  if (duty_q == '0) begin
                     dir_d  = DIR_UP;
                     duty_d = duty_q + PWM_W'(1);
                  end else begin
                     duty_d = duty_q - PWM_W'(1);
                  end
               end
`else
               pat_d = ~pat_q;
`endif
            end
         endcase
      end
`ifdef LED_PWM_EN
      if (mode_d == MODE_BREATHE) begin
         led_d = {N_LED{pwm_d < duty_d}};
      end else begin
         led_d = pat_d;
      end
`else
      led_d = pat_d;
`endif
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         mode_q <= MODE_COUNT;
         dir_q  <= DIR_UP;
         pat_q  <= '0;
         led_q  <= '0;
         step_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         dir_q  <= dir_d;
         pat_q  <= pat_d;
         led_q  <= led_d;
         step_q <= step_d;
      end
   end

`ifdef LED_PWM_EN
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         pwm_q  <= '0;
         duty_q <= '0;
      end else begin
         pwm_q  <= pwm_d;
         duty_q <= duty_d;
      end
   end
`endif

   assign oLED  = led_q;
   assign oSTEP = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen (N_LED=8, DIV=4) plus directed timing checks.
`timescale 1ns/1ps
module tb_led_pattern_gen;

   localparam int unsigned N_LED = 8;
   localparam int unsigned DIV   = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic [1:0]       mode;
   logic [N_LED-1:0] led;
   logic             step;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [N_LED:0] sb_q[$];
   logic [N_LED:0] sb_exp;

   int unsigned m_cnt;
   logic [7:0]  m_pat;
   logic        m_down;
   logic [1:0]  m_mode;
   logic [7:0]  m_duty;
   logic [7:0]  m_pwm;
   logic [7:0]  m_led;
   logic        m_step;

   led_pattern_gen #(
      .N_LED(N_LED),
      .DIV  (DIV)
   ) dut (
      .iCLK  (clk),
      .iRST_N(rst_n),
      .iEN   (en),
      .iMODE (mode),
      .oLED  (led),
      .oSTEP (step)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update();
      if (!rst_n) begin
         m_cnt  = 0;
         m_pat  = 8'h00;
         m_down = 1'b0;
         m_mode = 2'd0;
         m_duty = 8'h00;
         m_pwm  = 8'h00;
         m_step = 1'b0;
         m_led  = 8'h00;
         sb_q.delete();
      end else begin
         m_pwm = m_pwm + 8'd1;
         if (mode !== m_mode) begin
            m_mode = mode;
            m_pat  = 8'h00;
            m_down = 1'b0;
            m_cnt  = 0;
            m_duty = 8'h00;
            m_step = 1'b0;
         end else begin
            m_step = en && (m_cnt == DIV - 1);
            if (en) m_cnt = m_step ? 0 : m_cnt + 1;
            if (m_step) begin
               case (m_mode)
                  2'd0: m_pat = m_pat + 8'd1;
                  2'd1: m_pat = ($countones(m_pat) != 1) ? 8'h01 : {m_pat[6:0], m_pat[7]};
                  2'd2: begin
                     if ($countones(m_pat) != 1) begin
                        m_pat  = 8'h01;
                        m_down = 1'b0;
                     end else if (!m_down && m_pat == 8'h80) begin
                        m_down = 1'b1;
                        m_pat  = 8'h40;
                     end else if (m_down && m_pat == 8'h01) begin
                        m_down = 1'b0;
                        m_pat  = 8'h02;
                     end else begin
                        m_pat = m_down ? (m_pat >> 1) : (m_pat << 1);
                     end
                  end
                  default: begin
`ifdef LED_PWM_EN
                     if (!m_down) begin
                        if (m_duty == 8'hFF) begin
                           m_down = 1'b1;
                           m_duty = 8'hFE;
                        end else begin
                           m_duty = m_duty + 8'd1;
                        end
                     end else begin
                        if (m_duty == 8'h00) begin
                           m_down = 1'b0;
                           m_duty = 8'h01;
                        end else begin
                           m_duty = m_duty - 8'd1;
                        end
                     end
`else
                     m_pat = (m_pat == 8'h00) ? 8'hFF : 8'h00;
`endif
                  end
               endcase
            end
         end
         m_led = m_pat;
`ifdef LED_PWM_EN
         if (m_mode == 2'd3) m_led = (m_pwm < m_duty) ? 8'hFF : 8'h00;
`endif
      end
      sb_q.push_back({m_led, m_step});
   endtask

   always @(posedge clk or negedge rst_n) model_update();

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         sb_exp = sb_q.pop_front();
         check("scoreboard", {led, step}, sb_exp);
      end
   end

   task automatic cycles(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_step(input string tag);
      logic seen;
      seen = 1'b0;
      for (int unsigned i = 0; i < 3 * DIV && !seen; i++) begin
         @(posedge clk);
         #1;
         seen = step;
      end
      check({tag, "_seen"}, seen, 1);
   endtask

   task automatic count_high(input string tag, input int unsigned exp);
      int unsigned hi;
      hi = 0;
      for (int unsigned i = 0; i < 256; i++) begin
         cycles(1);
         if (led == 8'hFF) hi++;
      end
      check(tag, hi, exp);
   endtask

   initial begin
      logic [7:0] bexp [16];
      logic [7:0] held;
      bexp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

      rst_n = 1'b0;
      en    = 1'b1;
      mode  = 2'd0;
      cycles(3);
      check("rst_led", led, 0);
      check("rst_step", step, 0);

      // count mode: first tick on the 4th enabled edge
      rst_n = 1'b1;
      cycles(3);
      check("pre_tick", {led, step}, 0);
      cycles(1);
      check("first_tick", {led, step}, {8'h01, 1'b1});
      cycles(1);
      check("step_one_cycle", step, 0);
      cycles(DIV - 1);
      check("second_tick", {led, step}, {8'h02, 1'b1});
      cycles(254 * DIV);
      check("count_wrap", {led, step}, {8'h00, 1'b1});

      // bounce sequence
      mode = 2'd2;
      cycles(1);
      check("bounce_clr", {led, step}, 0);
      for (int unsigned i = 0; i < 16; i++) begin
         wait_step("bounce");
         check("bounce_led", led, bexp[i]);
      end

      // rotate, then switch to count one cycle before a tick
      mode = 2'd1;
      cycles(1);
      for (int unsigned i = 0; i < 3; i++) begin
         wait_step("rotate");
         check("rotate_led", led, bexp[i]);
      end
      cycles(DIV - 1);
      mode = 2'd0;
      cycles(1);
      check("mchg_clr", {led, step}, 0);
      cycles(DIV - 1);
      check("mchg_no_tick", {led, step}, 0);
      cycles(1);
      check("mchg_tick", {led, step}, {8'h01, 1'b1});

      // enable drop at cnt=2
      cycles(2);
      en = 1'b0;
      cycles(10);
      check("en_freeze", {led, step}, {8'h01, 1'b0});
      en = 1'b1;
      cycles(1);
      check("en_resume_wait", step, 0);
      cycles(1);
      check("en_resume_tick", {led, step}, {8'h02, 1'b1});

      // mode 3
      mode = 2'd3;
      cycles(1);
      check("m3_clr", led, 0);
`ifdef LED_PWM_EN
      cycles(64 * DIV);
      en = 1'b0;
      count_high("pwm_duty64", 64);
      en = 1'b1;
      cycles(191 * DIV);
      en = 1'b0;
      count_high("pwm_duty255", 255);
      en = 1'b1;
      cycles(DIV);
      en = 1'b0;
      count_high("pwm_duty254", 254);
      en = 1'b1;
`else
      for (int unsigned i = 0; i < 4; i++) begin
         wait_step("blink");
         check("blink_led", led, (i % 2 == 0) ? 8'hFF : 8'h00);
      end
`endif

      // reset mid-bounce
      mode = 2'd2;
      cycles(1);
      for (int unsigned i = 0; i < 5; i++) wait_step("bounce2");
      held = led;
      check("bounce_at_0x10", held, 8'h10);
      rst_n = 1'b0;
      #1;
      check("async_rst", {led, step}, 0);
      mode = 2'd0;
      cycles(2);
      rst_n = 1'b1;
      cycles(DIV - 1);
      check("restart_pre", {led, step}, 0);
      cycles(1);
      check("restart_tick", {led, step}, {8'h01, 1'b1});

      cycles(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
